// File: rtl/amul_prof_pkg.sv
// Shared definitions for the approximate-multiplier error profiler.
// Holds the sweep FSM state type, the default operand width and the
// widths derived from it, and the pipeline drain length.
package amul_prof_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned W            = 8;
  localparam int unsigned PW           = 2 * W;      // product width
  localparam int unsigned CNTW         = 2 * W;      // sweep counter width
  localparam int unsigned ECW          = 2 * W + 1;  // error count / signed diff width
  localparam int unsigned DRAIN_CYCLES = 2;

endpackage

// File: rtl/amul_err_accum.sv
// Stage C of the profiler: forms the exact product of the sampled operands,
// the signed error of the multiplier output against it, and folds that error
// into the running statistics on the next edge when valid is set.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : zero all statistics (takes priority over accumulation)
//   valid         : x/y/z carry a pair to be scored this cycle
//   x, y, z       : operands and the multiplier's product for that pair
//   err_count     : pairs with z != x*y
//   sum_abs_err   : sum of |z - x*y|, modular
//   bias_sum      : signed sum of (z - x*y), two's complement, modular
//   max_abs_err   : largest |z - x*y| seen
//   max_x, max_y  : operands of the first pair that reached max_abs_err
module amul_err_accum #(
  parameter int unsigned W    = 8,
  parameter int unsigned SUMW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid,
  input  logic [W-1:0]      x,
  input  logic [W-1:0]      y,
  input  logic [2*W-1:0]    z,
  output logic [2*W:0]      err_count,
  output logic [SUMW-1:0]   sum_abs_err,
  output logic [SUMW:0]     bias_sum,
  output logic [2*W-1:0]    max_abs_err,
  output logic [W-1:0]      max_x,
  output logic [W-1:0]      max_y
);

  localparam int unsigned PW  = 2 * W;
  localparam int unsigned ECW = 2 * W + 1;
  localparam int unsigned BXW = SUMW + 1 - ECW;

  import amul_prof_pkg::*;

  logic [PW-1:0]  exact;
  logic [ECW-1:0] diff;
  logic [PW-1:0]  abs_err;
  logic [SUMW:0]  diff_ext;

  always_comb begin
    exact    = PW'(x) * PW'(y);
    diff     = {1'b0, z} - {1'b0, exact};
    // |diff| never exceeds 2^PW - 1, so the magnitude fits in PW bits.
    abs_err  = diff[ECW-1] ? PW'(-diff) : diff[PW-1:0];
    diff_ext = {{BXW{diff[ECW-1]}}, diff};
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      bias_sum    <= '0;
      max_abs_err <= '0;
      max_x       <= '0;
      max_y       <= '0;
    end else if (valid) begin
      if (diff != '0) begin
        err_count <= err_count + ECW'(1);
      end
      sum_abs_err <= sum_abs_err + SUMW'(abs_err);
      bias_sum    <= bias_sum + diff_ext;
      // Strictly greater: ties keep the earliest pair in sweep order.
      if (abs_err > max_abs_err) begin
        max_abs_err <= abs_err;
        max_x       <= x;
        max_y       <= y;
      end
    end
  end

endmodule

// File: rtl/amul_err_profiler.sv
// Exhaustive error-characterisation engine for an unsigned W x W approximate
// multiplier. Drives every operand pair (x fastest) into the combinational
// multiplier, samples its product one edge later and scores it against the
// exact product in amul_err_accum.
//   clk, rst     : clock, synchronous active-high reset (aborts a sweep)
//   start        : pulse to begin a sweep; only honoured in IDLE
//   busy         : high from the start edge until the done cycle
//   done         : one-cycle pulse, statistics valid from this cycle
//   x_o, y_o     : registered operands to the multiplier
//   z_i          : multiplier product for x_o/y_o, same cycle
//   err_count, sum_abs_err, bias_sum, max_abs_err, max_x, max_y : statistics
module amul_err_profiler #(
  parameter int unsigned W    = amul_prof_pkg::W,
  parameter int unsigned SUMW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      x_o,
  output logic [W-1:0]      y_o,
  input  logic [2*W-1:0]    z_i,
  output logic [2*W:0]      err_count,
  output logic [SUMW-1:0]   sum_abs_err,
  output logic [SUMW:0]     bias_sum,
  output logic [2*W-1:0]    max_abs_err,
  output logic [W-1:0]      max_x,
  output logic [W-1:0]      max_y
);

  localparam int unsigned PW   = 2 * W;
  localparam int unsigned CNTW = 2 * W;

  import amul_prof_pkg::*;

  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_t          state, state_nx;
  logic            sweep_start;
  logic [CNTW-1:0] cnt;
  logic [1:0]      drain_cnt;
  logic            valid_a;
  logic            valid_b;
  logic [W-1:0]    x_b, y_b;
  logic [PW-1:0]   z_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    busy        = 1'b0;
    done        = 1'b0;
    sweep_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx    = SWEEP;
          sweep_start = 1'b1;
        end
      end
      SWEEP: begin
        busy = 1'b1;
        // cnt reads zero only once it has wrapped past the last pair.
        if (cnt == '0) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage A: cnt runs one pair ahead of x_o/y_o, so the start edge loads
  // pair 0 directly and cnt starts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      x_o       <= '0;
      y_o       <= '0;
      valid_a   <= 1'b0;
      drain_cnt <= '0;
      valid_b   <= 1'b0;
      x_b       <= '0;
      y_b       <= '0;
      z_b       <= '0;
    end else begin
      if (sweep_start) begin
        cnt     <= CNTW'(1);
        x_o     <= '0;
        y_o     <= '0;
        valid_a <= 1'b1;
      end else if (state == SWEEP) begin
        if (cnt == '0) begin
          valid_a <= 1'b0;
        end else begin
          x_o <= cnt[W-1:0];
          y_o <= cnt[CNTW-1:W];
          cnt <= cnt + CNTW'(1);
        end
      end

      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 2'd1;
      end else begin
        drain_cnt <= '0;
      end

      // Stage B
      valid_b <= valid_a;
      x_b     <= x_o;
      y_b     <= y_o;
      z_b     <= z_i;
    end
  end

  amul_err_accum #(
    .W    (W),
    .SUMW (SUMW)
  ) u_accum (
    .clk         (clk),
    .rst         (rst),
    .clear       (sweep_start),
    .valid       (valid_b),
    .x           (x_b),
    .y           (y_b),
    .z           (z_b),
    .err_count   (err_count),
    .sum_abs_err (sum_abs_err),
    .bias_sum    (bias_sum),
    .max_abs_err (max_abs_err),
    .max_x       (max_x),
    .max_y       (max_y)
  );

endmodule

// File: tb/tb_amul_err_profiler.sv
// Scoreboard bench for amul_err_profiler, run at W=4 so each sweep is short.
// The stimulus process picks a multiplier behaviour, starts a sweep and pushes
// the statistics computed by a direct loop over all operand pairs; the monitor
// pops and compares on every done pulse.
module tb_amul_err_profiler;

  localparam int W        = 4;
  localparam int PW       = 2 * W;
  localparam int SUMW     = 20;
  localparam int NP       = 1 << (2 * W);
  localparam int OMAX     = (1 << W) - 1;
  localparam int DONE_LAT = NP + 2;

  typedef struct {
    longint errc;
    longint sum;
    longint bias;
    longint maxe;
    longint mx;
    longint my;
    longint dcyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done;
  logic [W-1:0]      x_o, y_o;
  logic [PW-1:0]     z_i;
  logic [PW:0]       err_count;
  logic [SUMW-1:0]   sum_abs_err;
  logic [SUMW:0]     bias_sum;
  logic [PW-1:0]     max_abs_err;
  logic [W-1:0]      max_x, max_y;

  int     mode = 0;
  int     and_mask = 0;
  int     xor_mask = 0;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     done_events = 0;
  exp_t   exp_q[$];
  exp_t   last_exp;

  amul_err_profiler #(
    .W    (W),
    .SUMW (SUMW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .x_o         (x_o),
    .y_o         (y_o),
    .z_i         (z_i),
    .err_count   (err_count),
    .sum_abs_err (sum_abs_err),
    .bias_sum    (bias_sum),
    .max_abs_err (max_abs_err),
    .max_x       (max_x),
    .max_y       (max_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier variants: 0 exact, 1 exact+1, 2 always zero, 3 masked/perturbed.
  function automatic int mult_model(input int m, input int x, input int y,
                                    input int am, input int xm);
    int p;
    p = x * y;
    case (m)
      0:       return p;
      1:       return (p + 1) % (1 << PW);
      2:       return 0;
      default: return (p & am) ^ ((x & y) & xm);
    endcase
  endfunction

  always_comb z_i = PW'(mult_model(mode, int'(x_o), int'(y_o), and_mask, xor_mask));

  function automatic exp_t compute_expected(input int m, input int am, input int xm);
    exp_t e;
    longint d, a;
    e = '{default: 0};
    for (int y = 0; y <= OMAX; y++) begin
      for (int x = 0; x <= OMAX; x++) begin
        d = longint'(mult_model(m, x, y, am, xm)) - longint'(x * y);
        a = (d < 0) ? -d : d;
        if (d != 0) e.errc++;
        e.sum  += a;
        e.bias += d;
        if (a > e.maxe) begin
          e.maxe = a;
          e.mx   = x;
          e.my   = y;
        end
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_events++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done seen at cycle %0d with no sweep pending", cyc);
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
        check("done_cycle", cyc, e.dcyc);
        check("err_count", longint'(err_count), e.errc);
        check("sum_abs_err", longint'(sum_abs_err), e.sum);
        check("bias_sum", longint'($signed(bias_sum)), e.bias);
        check("max_abs_err", longint'(max_abs_err), e.maxe);
        check("max_x", longint'(max_x), e.mx);
        check("max_y", longint'(max_y), e.my);
      end
      check("busy_at_done", longint'(busy), 0);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_x_o"}, longint'(x_o), 0);
    check({tag, "_y_o"}, longint'(y_o), 0);
    check({tag, "_err_count"}, longint'(err_count), 0);
    check({tag, "_sum_abs_err"}, longint'(sum_abs_err), 0);
    check({tag, "_bias_sum"}, longint'(bias_sum), 0);
    check({tag, "_max_abs_err"}, longint'(max_abs_err), 0);
    check({tag, "_max_x"}, longint'(max_x), 0);
    check({tag, "_max_y"}, longint'(max_y), 0);
  endtask

  // Issues the start pulse, queues the expected result and checks that the
  // statistics were cleared by the start edge.
  task automatic start_sweep(input int m, input int am, input int xm);
    exp_t e;
    longint k;
    @(negedge clk);
    mode     = m;
    and_mask = am;
    xor_mask = xm;
    start    = 1'b1;
    k        = cyc + 1;
    e        = compute_expected(m, am, xm);
    e.dcyc   = k + DONE_LAT;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", longint'(busy), 1);
    check("clear_err_count", longint'(err_count), 0);
    check("clear_sum_abs_err", longint'(sum_abs_err), 0);
    check("clear_max_abs_err", longint'(max_abs_err), 0);
    check("first_pair_x", longint'(x_o), 0);
  endtask

  task automatic wait_done();
    int prev;
    int n;
    prev = done_events;
    n    = 0;
    while (done_events == prev && n < DONE_LAT + 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_events == prev) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", DONE_LAT + 20);
      exp_q.delete();
    end
  endtask

  task automatic hold_check();
    repeat (3) @(negedge clk);
    check("hold_err_count", longint'(err_count), last_exp.errc);
    check("hold_sum_abs_err", longint'(sum_abs_err), last_exp.sum);
    check("hold_max_abs_err", longint'(max_abs_err), last_exp.maxe);
    check("hold_x_o", longint'(x_o), OMAX);
    check("hold_y_o", longint'(y_o), OMAX);
    check("idle_busy", longint'(busy), 0);
  endtask

  task automatic full_sweep(input int m, input int am, input int xm);
    start_sweep(m, am, xm);
    wait_done();
    hold_check();
  endtask

  initial begin
    int am, xm, prev;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    full_sweep(0, 0, 0);
    full_sweep(1, 0, 0);
    full_sweep(2, 0, 0);

    // Extra start pulses mid-sweep must be ignored.
    start_sweep(2, 0, 0);
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (150) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    hold_check();

    // Reset mid-sweep: everything clears, no done follows.
    start_sweep(2, 0, 0);
    repeat (98) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    rst = 1'b0;
    exp_q.delete();
    prev = done_events;
    repeat (DONE_LAT + 10) @(negedge clk);
    check("no_done_after_abort", longint'(done_events - prev), 0);
    full_sweep(2, 0, 0);

    // Back-to-back: second start in the cycle right after done.
    am = int'($urandom_range(0, (1 << PW) - 1));
    xm = int'($urandom_range(0, (1 << PW) - 1));
    start_sweep(3, am, xm);
    wait_done();
    start_sweep(3, am, xm);
    wait_done();
    hold_check();

    for (int i = 0; i < 4; i++) begin
      am = int'($urandom_range(0, (1 << PW) - 1));
      xm = int'($urandom_range(0, (1 << PW) - 1));
      full_sweep(3, am, xm);
    end

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_results: %0d sweeps never reported done", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
